cam_capture: RTL and testbench

Parametrised DVP camera capture front end, successor to the fixed RGB565 capture block. It samples the sensor's `pclk`, `vsync`, `href` and data pins in the system clock domain and assembles bytes into pixels for RGB565, RGB555, YUV422 (luma only) and RAW8 formats. Each pixel is emitted as 8-bit R/G/B with x/y coordinates and frame and line markers. It feeds the grayscale and edge-detection pipeline directly.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_sync_edge.sv | 32 +++
 rtl/cam_capture.sv | 214 +++++++++++++++++++++
 tb/tb_cam_capture.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and the byte-pair to RGB888 decoder for the DVP capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        CAM_RGB565 = 2'd0,
        CAM_RGB555 = 2'd1,
        CAM_YUV422 = 2'd2,
        CAM_RAW8   = 2'd3
    } cam_mode_t;

    typedef enum logic [2:0] {
        WAIT_VB = 3'd0,
        WAIT_FR = 3'd1,
        IDLE_LN = 3'd2,
        B0      = 3'd3,
        B1      = 3'd4
    } cam_cap_state_t;

    // Channels narrower than 8 bits are widened by replicating their MSBs.
    function automatic logic [23:0] cam_unpack(input cam_mode_t mode,
                                               input logic [7:0] byte0,
                                               input logic [7:0] byte1);
        logic [15:0] p;
        p = {byte0, byte1};
        case (mode)
            CAM_RGB565: cam_unpack = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
            CAM_RGB555: cam_unpack = {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
            default:    cam_unpack = {3{byte0}};
        endcase
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// N-stage synchroniser for a strobe pin plus an aligned data bus; the strobe
// chain carries one extra stage so its rising edge yields a one-cycle pulse.
module cam_sync_edge #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         edge_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         rise_o
);

    logic [W-1:0] data_q [N];
    logic [N:0]   edge_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) data_q[i] <= '0;
            edge_q <= '0;
        end else begin
            data_q[0] <= din_i;
            for (int i = 1; i < N; i++) data_q[i] <= data_q[i-1];
            edge_q <= {edge_q[N-1:0], edge_i};
        end
    end

    assign dout_o = data_q[N-1];
    assign rise_o = edge_q[N-1] & ~edge_q[N];

endmodule

// File: rtl/cam_capture.sv
// DVP camera capture: sync sensor pins, assemble bytes into RGB888 pixels with coordinates.
// Optional crop window enabled by defining CAM_CAPTURE_CROP_EN.
module cam_capture #(
    parameter int   DATA_W      = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 11,
    parameter logic VSYNC_POL   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pclk,
    input  logic              vsync,
    input  logic              href,
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        mode,
`ifdef CAM_CAPTURE_CROP_EN
    input  logic [CNT_W-1:0]  crop_x0,
    input  logic [CNT_W-1:0]  crop_x1,
    input  logic [CNT_W-1:0]  crop_y0,
    input  logic [CNT_W-1:0]  crop_y1,
`endif
    output logic              pix_valid,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic              sof,
    output logic              eol,
    output logic              frame_done,
    output logic              line_err,
    output logic [2:0]        dbg_state
);
    import cam_pkg::*;

    // vsync, href and data share the pclk synchroniser so they stay aligned with its strobe.
    logic [DATA_W+1:0] pins_s;
    logic              stb;

    cam_sync_edge #(.N(SYNC_STAGES), .W(DATA_W + 2)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .edge_i  (pclk),
        .din_i   ({vsync, href, d}),
        .dout_o  (pins_s),
        .rise_o  (stb)
    );

    logic       vs_act;
    logic       href_s;
    logic [7:0] byte_s;

    assign vs_act = (pins_s[DATA_W+1] == VSYNC_POL);
    assign href_s = pins_s[DATA_W];
    assign byte_s = pins_s[DATA_W-1 -: 8];

    cam_cap_state_t   state_q, state_d;
    cam_mode_t        mode_q, mode_d;
    logic [7:0]       byte0_q, byte0_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             first_q, first_d, any_q, any_d;
    logic             pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
    logic             fd_q, fd_d, lerr_q, lerr_d;
    logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [CNT_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;

    logic [CNT_W-1:0] xc;
    logic             emit, win, sof_pos;
    logic [7:0]       b0_sel;
    logic [23:0]      rgb;

    // The first byte of a line is handled in the IDLE_LN strobe with x already cleared.
    assign xc = (state_q == IDLE_LN) ? '0 : x_q;

`ifdef CAM_CAPTURE_CROP_EN
    assign win     = (xc >= crop_x0) && (xc <= crop_x1) && (y_q >= crop_y0) && (y_q <= crop_y1);
    assign sof_pos = 1'b1;
`else
    assign win     = 1'b1;
    assign sof_pos = (xc == '0) && (y_q == '0);
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        byte0_d     = byte0_q;
        x_d         = x_q;
        y_d         = y_q;
        first_d     = first_q;
        any_d       = any_q;
        pix_valid_d = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        fd_d        = 1'b0;
        lerr_d      = 1'b0;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        px_x_d      = px_x_q;
        px_y_d      = px_y_q;
        emit        = 1'b0;
        b0_sel      = byte_s;

        if (stb) begin
            case (state_q)
                WAIT_VB: if (vs_act) state_d = WAIT_FR;
                WAIT_FR: begin
                    if (!vs_act) begin
                        state_d = IDLE_LN;
                        mode_d  = cam_mode_t'(mode);
                        y_d     = '0;
                        first_d = 1'b1;
                        any_d   = 1'b0;
                    end
                end
                default: begin
                    if ((state_q != IDLE_LN) && !href_s) begin
                        state_d = IDLE_LN;
                        eol_d   = 1'b1;
                        y_d     = (&y_q) ? y_q : y_q + 1'b1;
                        lerr_d  = (state_q == B1) && (mode_q != CAM_RAW8);
                    end
                    // Frame end overrides everything, including a pixel on the same strobe.
                    if (vs_act) begin
                        state_d = WAIT_FR;
                        fd_d    = any_q;
                    end else if (href_s) begin
                        x_d = xc;
                        if (state_q == B1) begin
                            emit    = 1'b1;
                            b0_sel  = byte0_q;
                            state_d = B0;
                        end else if (mode_q == CAM_RAW8) begin
                            emit    = 1'b1;
                            state_d = B0;
                        end else begin
                            byte0_d = byte_s;
                            state_d = B1;
                        end
                    end
                end
            endcase
        end

        rgb = cam_unpack(mode_q, b0_sel, byte_s);
        if (emit) begin
            red_d   = rgb[23:16];
            green_d = rgb[15:8];
            blue_d  = rgb[7:0];
            px_x_d  = xc;
            px_y_d  = y_q;
            x_d     = (&xc) ? xc : xc + 1'b1;
            if (win) begin
                pix_valid_d = 1'b1;
                sof_d       = first_q & sof_pos;
                first_d     = 1'b0;
                any_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_VB;
            mode_q      <= CAM_RGB565;
            byte0_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            first_q     <= 1'b0;
            any_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            fd_q        <= 1'b0;
            lerr_q      <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            px_x_q      <= '0;
            px_y_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            byte0_q     <= byte0_d;
            x_q         <= x_d;
            y_q         <= y_d;
            first_q     <= first_d;
            any_q       <= any_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            fd_q        <= fd_d;
            lerr_q      <= lerr_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            px_x_q      <= px_x_d;
            px_y_q      <= px_y_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign x          = px_x_q;
    assign y          = px_y_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign frame_done = fd_q;
    assign line_err   = lerr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: table of single-line frames plus hand-written corner sequences.
module tb_cam_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pclk, vsync, href;
    logic [7:0]  d;
    logic [1:0]  mode;
    logic        pix_valid, sof, eol, frame_done, line_err;
    logic [7:0]  red, green, blue;
    logic [10:0] x, y;
    logic [2:0]  dbg_state;
`ifdef CAM_CAPTURE_CROP_EN
    logic [10:0] crop_x0, crop_x1, crop_y0, crop_y1;
`endif

    always #5 clk = ~clk;

    cam_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .mode       (mode),
`ifdef CAM_CAPTURE_CROP_EN
        .crop_x0    (crop_x0),
        .crop_x1    (crop_x1),
        .crop_y0    (crop_y0),
        .crop_y1    (crop_y1),
`endif
        .pix_valid  (pix_valid),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .frame_done (frame_done),
        .line_err   (line_err),
        .dbg_state  (dbg_state)
    );

    // Monitor: captures pixels {sof, y, x, rgb} and counts strobe cycles.
    logic [46:0] act_mem [128];
    int act_n = 0, eol_cnt = 0, lerr_cnt = 0, fd_cnt = 0, eol_lerr_cnt = 0, eol_fd_cnt = 0;

    always @(negedge clk) begin
        if (pix_valid && act_n < 128) begin
            act_mem[act_n] <= {sof, y, x, red, green, blue};
            act_n <= act_n + 1;
        end
        if (eol) eol_cnt <= eol_cnt + 1;
        if (line_err) lerr_cnt <= lerr_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (eol && line_err) eol_lerr_cnt <= eol_lerr_cnt + 1;
        if (eol && frame_done) eol_fd_cnt <= eol_fd_cnt + 1;
    end

    // Scoreboard
    logic [46:0] exp_q[$];
    int checks = 0, errors = 0, rd = 0;
    int e0, l0, f0, el0, ef0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_pix(input logic [23:0] rgb, input int px, input int py, input logic s);
        logic [10:0] xx, yy;
        xx = px[10:0];
        yy = py[10:0];
        exp_q.push_back({s, yy, xx, rgb});
    endtask

    task automatic check_pixels(input string tag);
        logic [46:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < act_n) begin
                chk({tag, " pixel"}, act_mem[rd], e);
                rd++;
            end else begin
                checks++;
                errors++;
                $display("FAIL %s missing pixel actual=none expected=%0h", tag, e);
            end
        end
        chk({tag, " extra pixels"}, act_n - rd, 0);
        rd = act_n;
    endtask

    task automatic snap();
        e0 = eol_cnt; l0 = lerr_cnt; f0 = fd_cnt; el0 = eol_lerr_cnt; ef0 = eol_fd_cnt;
    endtask

    // Driver: one pclk period spans 8 system clocks, data set while pclk is low.
    task automatic send(input logic [7:0] b, input logic hr, input logic vs);
        @(negedge clk);
        d = b; href = hr; vsync = vs;
        repeat (3) @(negedge clk);
        pclk = 1'b1;
        repeat (4) @(negedge clk);
        pclk = 1'b0;
    endtask

    task automatic vsync_pulse();
        send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
    endtask

    task automatic frame_open();
        send(8'h00, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic [3:0]  nbytes;
        logic [47:0] bytes;
        logic [1:0]  npix;
        logic [71:0] rgb;
        logic        lerr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mode: 2'd0, nbytes: 4'd6, bytes: 48'hF80007E0001F, npix: 2'd3,
                    rgb: 72'hFF0000_00FF00_0000FF, lerr: 1'b0};
        vecs[1] = '{mode: 2'd1, nbytes: 4'd6, bytes: 48'h7C0003E04210, npix: 2'd3,
                    rgb: 72'hFF0000_00FF00_848484, lerr: 1'b0};
        vecs[2] = '{mode: 2'd0, nbytes: 4'd5, bytes: 48'hF8001234AA00, npix: 2'd2,
                    rgb: 72'hFF0000_1045A5_000000, lerr: 1'b1};
        vecs[3] = '{mode: 2'd2, nbytes: 4'd4, bytes: 48'h8040C0B00000, npix: 2'd2,
                    rgb: 72'h808080_C0C0C0_000000, lerr: 1'b0};
        vecs[4] = '{mode: 2'd3, nbytes: 4'd3, bytes: 48'h1020FF000000, npix: 2'd3,
                    rgb: 72'h101010_202020_FFFFFF, lerr: 1'b0};
        vecs[5] = '{mode: 2'd2, nbytes: 4'd3, bytes: 48'h556677000000, npix: 2'd1,
                    rgb: 72'h555555_000000_000000, lerr: 1'b1};

        // Clock/reset
        reset_n = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; d = '0; mode = 2'd0;
`ifdef CAM_CAPTURE_CROP_EN
        crop_x0 = '0; crop_x1 = '1; crop_y0 = '0; crop_y1 = '1;
`endif
        repeat (3) @(negedge clk);
        chk("reset strobes", {pix_valid, sof, eol, frame_done, line_err}, 0);
        chk("reset rgb", {red, green, blue}, 0);
        chk("reset xy", {x, y}, 0);
        chk("reset state", dbg_state, 0);
        reset_n = 1'b1;
        vsync_pulse();

        // Table-driven single-line frames
        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            snap();
            frame_open();
            for (int k = 0; k < int'(vecs[v].npix); k++)
                push_pix(vecs[v].rgb[71-24*k -: 24], k, 0, k == 0);
            for (int k = 0; k < int'(vecs[v].nbytes); k++)
                send(vecs[v].bytes[47-8*k -: 8], 1'b1, 1'b0);
            send(8'h00, 1'b0, 1'b0);
            settle();
            check_pixels($sformatf("vec%0d", v));
            chk($sformatf("vec%0d eol count", v), eol_cnt - e0, 1);
            chk($sformatf("vec%0d line_err count", v), lerr_cnt - l0, vecs[v].lerr);
            chk($sformatf("vec%0d line_err with eol", v), eol_lerr_cnt - el0, vecs[v].lerr);
            vsync_pulse();
            settle();
            chk($sformatf("vec%0d frame_done", v), fd_cnt - f0, 1);
        end

        // Mode change mid-frame; second line checks y and sof
        mode = 2'd0;
        snap();
        frame_open();
        push_pix(24'hFF0000, 0, 0, 1'b1);
        push_pix(24'h00FF00, 1, 0, 1'b0);
        push_pix(24'h0000FF, 0, 1, 1'b0);
        send(8'hF8, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        mode = 2'd3;
        send(8'h07, 1'b1, 1'b0);
        send(8'hE0, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h1F, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        vsync_pulse();
        settle();
        check_pixels("mode hold");
        chk("mode hold eol count", eol_cnt - e0, 2);
        chk("mode hold frame_done", fd_cnt - f0, 1);

        // Next frame picks up RAW8, then vsync arrives together with href
        snap();
        frame_open();
        push_pix(24'h101010, 0, 0, 1'b1);
        push_pix(24'h202020, 1, 0, 1'b0);
        push_pix(24'h333333, 0, 1, 1'b0);
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b1);
        settle();
        check_pixels("raw8 vsync wins");
        chk("vsync wins eol count", eol_cnt - e0, 1);
        chk("vsync wins frame_done", fd_cnt - f0, 1);
        send(8'h00, 1'b0, 1'b1);

        // Empty frame gives no frame_done
        snap();
        frame_open();
        vsync_pulse();
        settle();
        chk("empty frame frame_done", fd_cnt - f0, 0);

        // Line end and frame end on the same strobe
        snap();
        frame_open();
        push_pix(24'h555555, 0, 0, 1'b1);
        push_pix(24'h666666, 1, 0, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        settle();
        check_pixels("coincide");
        chk("coincide eol with frame_done", eol_fd_cnt - ef0, 1);
        chk("coincide frame_done", fd_cnt - f0, 1);
        send(8'h00, 1'b0, 1'b1);

        // Reset mid-line
        mode = 2'd0;
        frame_open();
        push_pix(24'hFF0000, 0, 0, 1'b1);
        send(8'hF8, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b0);
        check_pixels("pre reset");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midline reset strobes", {pix_valid, sof, eol, frame_done, line_err}, 0);
        chk("midline reset rgb", {red, green, blue}, 0);
        chk("midline reset state", dbg_state, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(8'hE0, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h1F, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        settle();
        check_pixels("post reset no vblank");
        vsync_pulse();
        frame_open();
        push_pix(24'hFF0000, 0, 0, 1'b1);
        send(8'hF8, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        settle();
        check_pixels("post reset resume");

`ifdef CAM_CAPTURE_CROP_EN
        // Crop window x 1..2, y 1..1 on a 4x3 RAW8 frame
        vsync_pulse();
        mode = 2'd3;
        crop_x0 = 11'd1; crop_x1 = 11'd2; crop_y0 = 11'd1; crop_y1 = 11'd1;
        settle();
        snap();
        frame_open();
        push_pix(24'h111111, 1, 1, 1'b1);
        push_pix(24'h121212, 2, 1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) send(8'(16 * r + c), 1'b1, 1'b0);
            send(8'h00, 1'b0, 1'b0);
        end
        vsync_pulse();
        settle();
        check_pixels("crop");
        chk("crop frame_done", fd_cnt - f0, 1);
        chk("crop eol count", eol_cnt - e0, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
